// File: rtl/udp_echo_responder_if.sv
// udp_echo_responder_if: UDP datagram port (header handshake plus byte-wide payload stream).
// Signals:
//   hdr_valid/hdr_ready               header handshake
//   ip                                peer IP (source on rx, destination on tx)
//   source_port/dest_port/length      UDP header fields, length includes the 8-byte header
//   tdata/tvalid/tready/tlast/tuser   payload stream, tuser=1 marks a bad frame
// The master modport drives a datagram; the slave modport accepts one.
interface udp_echo_responder_if;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [31:0] ip;
    logic [15:0] source_port;
    logic [15:0] dest_port;
    logic [15:0] length;
    logic [7:0]  tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;
    modport master (
        output hdr_valid, ip, source_port, dest_port, length, tdata, tvalid, tlast, tuser,
        input  hdr_ready, tready
    );
    modport slave (
        input  hdr_valid, ip, source_port, dest_port, length, tdata, tvalid, tlast, tuser,
        output hdr_ready, tready
    );
endinterface

// File: rtl/udp_echo_responder.sv
// udp_echo_responder: store-and-forward UDP echo, buffers one datagram for LISTEN_PORT and sends it back.
// Ports:
//   sys_clk       single clock
//   system_reset  asynchronous active-high reset
//   s_udp         received datagram (slave side of the UDP stack rx output)
//   m_udp         echoed datagram (master side into the UDP stack tx input)
//   drop_count    saturating count of discarded datagrams
//   busy          high whenever a datagram is being received, dropped or sent
module udp_echo_responder #(
    parameter logic [15:0] LISTEN_PORT       = 16'd1234,
    parameter int          MAX_PAYLOAD_BYTES = 1472,
    parameter int          ADDR_WIDTH        = 11
) (
    input  logic                  sys_clk,
    input  logic                  system_reset,
    udp_echo_responder_if.slave   s_udp,
    udp_echo_responder_if.master  m_udp,
    output logic [15:0]           drop_count,
    output logic                  busy
);
    typedef enum logic [2:0] {IDLE, RX_PAYLOAD, DROP, TX_HDR, TX_PAYLOAD} state_t;
    state_t state, state_next;
    // Reset asserts immediately but releases two clocks after system_reset falls.
    logic [1:0] rst_pipe;
    logic rst;
    logic [31:0] ip_q;
    logic [15:0] sport_q, dport_q, len_q, plen;
    logic [ADDR_WIDTH-1:0] count, rd_cnt;
    logic [7:0] mem [2**ADDR_WIDTH];
    logic [7:0] rd_data;
    logic tx_valid, tx_last;
    logic hdr_fire, rx_beat, rx_wr, hdr_ok, rx_len_ok, rx_full, rd_en, drop_inc;
    assign rst = rst_pipe[1];
    always_ff @(posedge sys_clk or posedge system_reset) begin
        if (system_reset) rst_pipe <= 2'b11;
        else rst_pipe <= {rst_pipe[0], 1'b0};
    end
    assign plen      = len_q - 16'd8;
    assign hdr_fire  = s_udp.hdr_valid && s_udp.hdr_ready;
    assign rx_beat   = s_udp.tvalid && s_udp.tready;
    assign rx_wr     = rx_beat && state == RX_PAYLOAD;
    assign hdr_ok    = s_udp.dest_port == LISTEN_PORT && s_udp.length >= 16'd9 &&
                       (s_udp.length - 16'd8) <= 16'(MAX_PAYLOAD_BYTES);
    assign rx_len_ok = 16'(count) + 16'd1 == plen;
    assign rx_full   = count == ADDR_WIDTH'(MAX_PAYLOAD_BYTES - 1);
    assign drop_inc  = rx_beat && s_udp.tlast &&
                       (state == DROP || (state == RX_PAYLOAD && (s_udp.tuser || !rx_len_ok)));
    // Refill the output register whenever it is empty or being taken this cycle.
    assign rd_en     = state == TX_PAYLOAD && (!tx_valid || m_udp.tready) && 16'(rd_cnt) < plen;
    assign busy = state != IDLE;
    assign m_udp.ip          = ip_q;
    assign m_udp.source_port = dport_q;
    assign m_udp.dest_port   = sport_q;
    assign m_udp.length      = len_q;
    assign m_udp.tvalid      = tx_valid;
    assign m_udp.tlast       = tx_last;
    assign m_udp.tuser       = 1'b0;
    assign m_udp.tdata       = tx_valid ? rd_data : 8'd0;
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end
    always_comb begin
        state_next      = state;
        s_udp.hdr_ready = 1'b0;
        s_udp.tready    = 1'b0;
        m_udp.hdr_valid = 1'b0;
        case (state)
            IDLE: begin
                s_udp.hdr_ready = !rst;
                if (s_udp.hdr_valid && !rst) state_next = hdr_ok ? RX_PAYLOAD : DROP;
            end
            RX_PAYLOAD: begin
                s_udp.tready = 1'b1;
                if (s_udp.tvalid && s_udp.tlast)
                    state_next = (s_udp.tuser || !rx_len_ok) ? IDLE : TX_HDR;
                else if (s_udp.tvalid && rx_full)
                    state_next = DROP;
            end
            DROP: begin
                s_udp.tready = 1'b1;
                if (s_udp.tvalid && s_udp.tlast) state_next = IDLE;
            end
            TX_HDR: begin
                m_udp.hdr_valid = 1'b1;
                if (m_udp.hdr_ready) state_next = TX_PAYLOAD;
            end
            TX_PAYLOAD: begin
                if (tx_valid && m_udp.tready && tx_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ip_q       <= '0;
            sport_q    <= '0;
            dport_q    <= '0;
            len_q      <= '0;
            count      <= '0;
            rd_cnt     <= '0;
            tx_valid   <= 1'b0;
            tx_last    <= 1'b0;
            drop_count <= '0;
        end else begin
            if (hdr_fire) begin
                ip_q    <= s_udp.ip;
                sport_q <= s_udp.source_port;
                dport_q <= s_udp.dest_port;
                len_q   <= s_udp.length;
                count   <= '0;
            end else if (rx_wr) begin
                count <= count + 1'b1;
            end
            if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            if (state != TX_PAYLOAD) begin
                rd_cnt   <= '0;
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
            end else if (rd_en) begin
                rd_cnt   <= rd_cnt + 1'b1;
                tx_valid <= 1'b1;
                tx_last  <= 16'(rd_cnt) == plen - 16'd1;
            end else if (m_udp.tready) begin
                tx_valid <= 1'b0;
                tx_last  <= 1'b0;
            end
        end
    end
    // Payload buffer: plain write port and registered read port, no reset so it maps to block RAM.
    always_ff @(posedge sys_clk) begin
        if (rx_wr) mem[count] <= s_udp.tdata;
        if (rd_en) rd_data <= mem[rd_cnt];
    end
endmodule

// File: tb/tb_udp_echo_responder.sv
// tb_udp_echo_responder: directed stimulus with a queue scoreboard checked by an independent output monitor.
module tb_udp_echo_responder;
    logic clk = 1'b0;
    logic system_reset;
    logic [15:0] drop_count;
    logic busy;
    int checks = 0;
    int errors = 0;
    int exp_drop = 0;
    bit bp_mode = 1'b0;
    int hw = 0;
    logic [79:0] hdr_q[$];
    logic [8:0]  byte_q[$];

    udp_echo_responder_if s_if();
    udp_echo_responder_if m_if();

    udp_echo_responder dut (
        .sys_clk(clk),
        .system_reset(system_reset),
        .s_udp(s_if),
        .m_udp(m_if),
        .drop_count(drop_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out", name);
    endtask

    task automatic push_echo(input logic [31:0] ip, input logic [15:0] sport, input logic [15:0] len,
                             input int n, input logic [7:0] base);
        hdr_q.push_back({ip, 16'd1234, sport, len});
        for (int i = 0; i < n; i++) byte_q.push_back({i == n - 1, base + 8'(i)});
    endtask

    task automatic send_hdr(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                            input logic [15:0] len);
        int n = 0;
        s_if.ip = ip;
        s_if.source_port = sp;
        s_if.dest_port = dp;
        s_if.length = len;
        s_if.hdr_valid = 1'b1;
        while (!s_if.hdr_ready && n < 5000) begin @(negedge clk); n++; end
        if (n == 5000) timeout("rx_hdr_ready");
        @(posedge clk); #1;
        s_if.hdr_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last, input logic user);
        int n = 0;
        s_if.tdata = d;
        s_if.tlast = last;
        s_if.tuser = user;
        s_if.tvalid = 1'b1;
        while (!s_if.tready && n < 5000) begin @(negedge clk); n++; end
        if (n == 5000) timeout("rx_tready");
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
        s_if.tuser = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                            input logic [15:0] len, input int n, input logic [7:0] base,
                            input logic bad);
        send_hdr(ip, sp, dp, len);
        for (int i = 0; i < n; i++) send_beat(base + 8'(i), i == n - 1, bad && i == n - 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(busy == 1'b0 && hdr_q.size() == 0 && byte_q.size() == 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n == 5000) begin
            timeout(name);
            hdr_q.delete();
            byte_q.delete();
        end
        repeat (2) @(negedge clk);
        chk({name, "_drop_count"}, 96'(drop_count), 96'(exp_drop));
        chk({name, "_busy"}, 96'(busy), 96'd0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            if (!bp_mode) begin
                hw = 0;
                m_if.hdr_ready = 1'b1;
                m_if.tready = 1'b1;
            end else begin
                if (m_if.hdr_valid) hw++;
                m_if.hdr_ready = hw > 10;
                m_if.tready = !m_if.tready;
            end
        end
    end

    initial begin
        logic prev_hv = 1'b0;
        logic prev_dv = 1'b0;
        logic [79:0] prev_h;
        logic [8:0] prev_d;
        logic [79:0] cur_h;
        logic [8:0] cur_d;
        forever begin
            @(negedge clk);
            if (system_reset) begin
                prev_hv = 1'b0;
                prev_dv = 1'b0;
            end else begin
                cur_h = {m_if.ip, m_if.source_port, m_if.dest_port, m_if.length};
                cur_d = {m_if.tlast, m_if.tdata};
                if (prev_hv) chk("tx_hdr_stable", {m_if.hdr_valid, cur_h}, {1'b1, prev_h});
                if (prev_dv) chk("tx_data_stable", {m_if.tvalid, cur_d}, {1'b1, prev_d});
                if (m_if.hdr_valid && m_if.hdr_ready) begin
                    if (hdr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_hdr_unexpected actual %h required none", cur_h);
                    end else chk("tx_hdr", cur_h, hdr_q.pop_front());
                end
                if (m_if.tvalid && m_if.tready) begin
                    if (byte_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL tx_byte_unexpected actual %h required none", cur_d);
                    end else chk("tx_byte", {m_if.tuser, cur_d}, {1'b0, byte_q.pop_front()});
                end
                prev_hv = m_if.hdr_valid && !m_if.hdr_ready;
                prev_dv = m_if.tvalid && !m_if.tready;
                prev_h = cur_h;
                prev_d = cur_d;
            end
        end
    end

    initial begin
        system_reset = 1'b1;
        s_if.hdr_valid = 1'b0;
        s_if.ip = '0;
        s_if.source_port = '0;
        s_if.dest_port = '0;
        s_if.length = '0;
        s_if.tdata = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast = 1'b0;
        s_if.tuser = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk("rst_drop_count", 96'(drop_count), 96'd0);
        chk("rst_busy", 96'(busy), 96'd0);
        chk("rst_valids", {m_if.hdr_valid, m_if.tvalid}, 96'd0);
        chk("rst_readies", {s_if.hdr_ready, s_if.tready}, 96'd0);
        chk("rst_tx_fields", {m_if.ip, m_if.source_port, m_if.dest_port, m_if.length, m_if.tdata}, 96'd0);
        system_reset = 1'b0;
        repeat (4) @(posedge clk); #1;

        push_echo(32'hC0A8010A, 16'd40000, 16'd13, 5, 8'h01);
        send_pkt(32'hC0A8010A, 16'd40000, 16'd1234, 16'd13, 5, 8'h01, 1'b0);
        wait_idle("echo5");

        send_pkt(32'hC0A8010A, 16'd40000, 16'd80, 16'd12, 4, 8'h10, 1'b0);
        exp_drop++;
        wait_idle("wrong_port");

        send_pkt(32'hC0A8010A, 16'd40000, 16'd1234, 16'd12, 6, 8'h20, 1'b0);
        exp_drop++;
        wait_idle("len_mismatch");

        send_pkt(32'hC0A8010A, 16'd40000, 16'd1234, 16'd12, 4, 8'h30, 1'b1);
        exp_drop++;
        wait_idle("tuser_bad");

        send_pkt(32'hC0A8010A, 16'd40000, 16'd1234, 16'd1481, 4, 8'h40, 1'b0);
        exp_drop++;
        wait_idle("len_too_big");

        send_pkt(32'hC0A8010A, 16'd40000, 16'd1234, 16'd8, 1, 8'h50, 1'b0);
        exp_drop++;
        wait_idle("len_min");

        push_echo(32'h0A000002, 16'd7, 16'd9, 1, 8'h5A);
        send_pkt(32'h0A000002, 16'd7, 16'd1234, 16'd9, 1, 8'h5A, 1'b0);
        wait_idle("echo1");

        send_pkt(32'h0A000003, 16'd9, 16'd1234, 16'd1480, 1474, 8'h00, 1'b0);
        exp_drop++;
        wait_idle("overflow");

        push_echo(32'h0A000004, 16'd11, 16'd1480, 1472, 8'h80);
        send_pkt(32'h0A000004, 16'd11, 16'd1234, 16'd1480, 1472, 8'h80, 1'b0);
        wait_idle("echo_max");

        bp_mode = 1'b1;
        push_echo(32'hC0A80001, 16'd5555, 16'd72, 64, 8'h00);
        send_pkt(32'hC0A80001, 16'd5555, 16'd1234, 16'd72, 64, 8'h00, 1'b0);
        wait_idle("backpressure");
        bp_mode = 1'b0;

        send_hdr(32'h0A000009, 16'd100, 16'd1234, 16'd16);
        for (int i = 0; i < 3; i++) send_beat(8'hE0 + 8'(i), 1'b0, 1'b0);
        system_reset = 1'b1;
        exp_drop = 0;
        #2;
        chk("midrst_busy", 96'(busy), 96'd0);
        chk("midrst_drop_count", 96'(drop_count), 96'd0);
        chk("midrst_valids", {m_if.hdr_valid, m_if.tvalid}, 96'd0);
        chk("midrst_readies", {s_if.hdr_ready, s_if.tready}, 96'd0);
        chk("midrst_tx_fields", {m_if.ip, m_if.source_port, m_if.dest_port, m_if.length}, 96'd0);
        repeat (2) @(posedge clk); #1;
        system_reset = 1'b0;
        repeat (4) @(posedge clk); #1;

        push_echo(32'h0A000001, 16'd5000, 16'd13, 5, 8'hAA);
        send_pkt(32'h0A000001, 16'd5000, 16'd1234, 16'd13, 5, 8'hAA, 1'b0);
        wait_idle("post_reset_echo");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/udp_echo_responder.md
Name: udp_echo_responder

Overview:
- Store-and-forward UDP echo stage.
- Sits between the UDP stack's received-datagram output (header plus payload stream) and the same stack's transmit-datagram input. Replaces the plain payload FIFO loopback.
- Accepts one datagram addressed to LISTEN_PORT and buffers the whole payload.
- Checks the payload against the header length and the error flag, then re-emits the datagram with IP/port fields swapped. Bad or unwanted datagrams are counted and discarded.

Parameters:
- LISTEN_PORT, 16'd1234: UDP destination port that is echoed; all other ports are dropped.
- MAX_PAYLOAD_BYTES, 1472: largest accepted payload; sets buffer depth.
- ADDR_WIDTH, 11: buffer address width; 2**ADDR_WIDTH must be >= MAX_PAYLOAD_BYTES.

Ports:
- sys_clk  in  1  single clock for all logic
- system_reset  in  1  asynchronous, active-high reset
- s_udp_hdr_valid / s_udp_hdr_ready  in / out  1  rx header handshake
- s_udp_ip_source_ip  in  32  sender IP
- s_udp_source_port, s_udp_dest_port, s_udp_length  in  16 each  rx UDP header fields; length includes the 8-byte UDP header
- s_udp_payload_axis_tdata  in  8  rx payload byte
- s_udp_payload_axis_tvalid, tlast, tuser  in  1  rx payload controls; tuser=1 marks a bad frame
- s_udp_payload_axis_tready  out  1
- m_udp_hdr_valid / m_udp_hdr_ready  out / in  1  tx header handshake
- m_udp_ip_dest_ip  out  32  echo destination IP
- m_udp_source_port, m_udp_dest_port, m_udp_length  out  16 each  tx UDP header fields
- m_udp_payload_axis_tdata  out  8
- m_udp_payload_axis_tvalid, tlast, tuser  out  1
- m_udp_payload_axis_tready  in  1
- drop_count  out  16  count of discarded datagrams, saturating
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync deassert inside the block):
  - state=IDLE; all valid/ready outputs 0.
  - m_* header and data outputs 0; drop_count=0.
  - Any partial datagram, buffered or in flight, is abandoned. After reset the block waits in IDLE; an upstream payload still in progress is not consumed until a new header arrives.
- States: IDLE, RX_PAYLOAD, DROP, TX_HDR, TX_PAYLOAD.
- IDLE:
  - s_udp_hdr_ready=1; all other readies 0.
  - On header handshake: latch src IP, src port, dest port, length; clear byte count.
  - Go to RX_PAYLOAD when all hold: dest_port==LISTEN_PORT, length>=9, (length-8)<=MAX_PAYLOAD_BYTES (16-bit unsigned arithmetic).
  - Otherwise go to DROP.
- RX_PAYLOAD:
  - s_udp_payload_axis_tready=1.
  - Each beat writes mem[count] and increments count.
  - On a tlast beat: if tuser==1 or (count+1)!=(length-8), increment drop_count and go to IDLE; else go to TX_HDR.
  - On a non-tlast beat when count==MAX_PAYLOAD_BYTES-1: overflow, go to DROP (that beat is consumed).
- DROP:
  - tready=1; beats are discarded.
  - On a tlast beat: increment drop_count, go to IDLE.
- TX_HDR:
  - m_udp_hdr_valid=1 with m_udp_ip_dest_ip=latched src IP, m_udp_source_port=latched dest port, m_udp_dest_port=latched src port, m_udp_length=latched length.
  - Fields are stable while valid && !ready.
  - On handshake go to TX_PAYLOAD.
- TX_PAYLOAD:
  - Synchronous-read buffer with an output register; first tvalid appears no earlier than 1 cycle after the header handshake.
  - tdata=mem[rd], tuser=0; tlast=1 only on byte length-9.
  - Data is held stable under backpressure; no bubbles are required once streaming.
  - On the tlast handshake go to IDLE.
  - No rx input is accepted in TX_HDR or TX_PAYLOAD (all s_* readies 0).
- drop_count saturates at 16'hFFFF.
- Throughput: at most one datagram in the block; 1 byte/cycle each direction.

Test Plan:
- Echo: hdr(src 192.168.1.10:40000, dst port 1234, len 13) + bytes 01..05 → tx hdr dst_ip C0A8010A, sport 1234, dport 40000, len 13; payload 01..05, tlast on 05, tuser 0; drop_count 0.
- Wrong port: dst port 80, len 12, 4 bytes → all 4 bytes consumed, no tx header, drop_count=1, back to IDLE (busy=0).
- Length mismatch / tuser: len 12 with 6 bytes → drop_count+1. Len 12 with 4 bytes, tuser=1 on last → drop_count+1. Neither case produces tx output.
- Overflow and min length: len 1481 (payload 1473 > 1472) → DROP, drop_count+1. Len 8 → DROP, drop_count+1.
- Backpressure: m_udp_hdr_ready low 10 cycles, then tready toggling 1/0 over a 64-byte payload → header fields stable; bytes 00..3F in order, none lost or duplicated.
- Reset mid-packet: assert system_reset after 3 of 8 rx bytes → outputs 0, busy 0, drop_count 0. A following valid 5-byte datagram echoes correctly.
